// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared rounding-mode encodings and pipeline depth for mul_frac_pipe
package mul_pkg;

    // Rounding-mode encodings carried with each operand beat; 2'b11 behaves as truncate.
    typedef enum logic [1:0] {
        MODE_TRUNC     = 2'b00,
        MODE_RHU       = 2'b01,
        MODE_RNE       = 2'b10,
        MODE_TRUNC_ALT = 2'b11
    } round_mode_e;

    // Number of register stages between operand acceptance and result.
    localparam int STAGES = 3;

endpackage

// File: rtl/frac_round.sv
// rtl/frac_round.sv - combinational Q0.2W to Q0.W rounding (truncate / half-up / half-even)
//
// Ports:
//   p     in  2W  exact product
//   mode  in  2   rounding mode (mul_pkg::round_mode_e encoding)
//   r     out W   rounded upper half; never overflows since (2^W-1)^2 + 2^(W-1) < 2^2W
module frac_round
    import mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2*W-1:0] p,
    input  logic [1:0]     mode,
    output logic [W-1:0]   r
);

    localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         inc;

    always_comb begin
        hi  = p[2*W-1:W];
        lo  = p[W-1:0];
        inc = 1'b0;
        case (round_mode_e'(mode))
            // Half-up: discarded half >= 0.5 ulp bumps the result.
            MODE_RHU: inc = lo[W-1];
            // Half-even: exact ties only round up when the kept LSB is odd.
            MODE_RNE: inc = (lo > HALF) || ((lo == HALF) && hi[0]);
            default:  inc = 1'b0;
        endcase
        r = hi + W'(inc);
    end

endmodule

// File: rtl/mul_frac_pipe.sv
// rtl/mul_frac_pipe.sv - 3-stage pipelined unsigned Q0.W fractional multiplier with selectable rounding
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   in_valid_i   in   1   operand beat valid
//   in_ready_o   out  1   beat accepted this cycle when in_valid_i is high
//   a_i, b_i     in   W   Q0.W operands
//   mode_i       in   2   rounding mode, captured with the operands
//   out_valid_o  out  1   result valid
//   out_ready_i  in   1   downstream accepts result
//   p_o          out  W   rounded Q0.W product
//   p_full_o     out  2W  exact Q0.2W product
//   busy_o       out  1   any stage holds a valid beat
module mul_frac_pipe
    import mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  logic [1:0]     mode_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [W-1:0]   p_o,
    output logic [2*W-1:0] p_full_o,
    output logic           busy_o
);

    // Partial products are summed in pairs of B bits; odd W gets a zero partner.
    localparam int NG = (W + 1) / 2;

    logic            en;

    logic [2*NG-1:0] b_ext;
    logic [2*W-1:0]  pp     [2*NG];
    logic [2*W-1:0]  grp_d  [NG];

    logic            v1_q;
    logic [1:0]      mode1_q;
    logic [2*W-1:0]  grp_q  [NG];

    logic            v2_q;
    logic [1:0]      mode2_q;
    logic [2*W-1:0]  sum_d;
    logic [2*W-1:0]  sum_q;

    logic [W-1:0]    rounded;

    logic            v3_q;
    logic [W-1:0]    p_q;
    logic [2*W-1:0]  full_q;

    // Single global advance: the whole pipe moves unless the output is stuck.
    assign en          = !v3_q || out_ready_i;
    assign in_ready_o  = en;
    assign out_valid_o = v3_q;
    assign p_o         = p_q;
    assign p_full_o    = full_q;
    assign busy_o      = v1_q || v2_q || v3_q;

    always_comb begin
        b_ext = (2*NG)'(b_i);
        for (int i = 0; i < 2*NG; i++) begin
            pp[i] = b_ext[i] ? ((2*W)'(a_i) << i) : '0;
        end
        for (int g = 0; g < NG; g++) begin
            grp_d[g] = pp[2*g] + pp[2*g+1];
        end
    end

    always_comb begin
        sum_d = '0;
        for (int g = 0; g < NG; g++) begin
            sum_d = sum_d + grp_q[g];
        end
    end

    frac_round #(.W(W)) u_round (
        .p    (sum_q),
        .mode (mode2_q),
        .r    (rounded)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            mode1_q <= '0;
            for (int g = 0; g < NG; g++) begin
                grp_q[g] <= '0;
            end
            v2_q    <= 1'b0;
            mode2_q <= '0;
            sum_q   <= '0;
            v3_q    <= 1'b0;
            p_q     <= '0;
            full_q  <= '0;
        end else if (en) begin
            // Stage valids shift with their data, so bubbles stay in place during a stall.
            v1_q    <= in_valid_i;
            mode1_q <= mode_i;
            for (int g = 0; g < NG; g++) begin
                grp_q[g] <= grp_d[g];
            end
            v2_q    <= v1_q;
            mode2_q <= mode1_q;
            sum_q   <= sum_d;
            v3_q    <= v2_q;
            p_q     <= rounded;
            full_q  <= sum_q;
        end
    end

endmodule
